// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with optional parity, 1-2 stop bits and a held output word.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx_param #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset,
  input  logic                  rx,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned MID   = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST  = OVERSAMPLE - 1;
  localparam logic        ODD   = (PARITY_MODE == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                  rx_meta, rx_s;
  logic [2:0]            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      bit_idx, idx_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  par_acc, par_nxt;
  logic                  perr_q, perr_nxt;
  logic                  ferr_q, ferr_nxt;
  logic                  armed, armed_nxt;
  logic                  hit_c, bit_tick_c, bit_val_c, load_c;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Mid-bit reference point; the counter restarts here so bit spacing stays exact
  assign hit_c = (state != S_IDLE) &&
                 (cnt == ((state == S_START) ? CNT_W'(MID) : CNT_W'(LAST)));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  logic       tick_q;

  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      hist   <= 2'b11;
      tick_q <= 1'b0;
    end else begin
      hist   <= {hist[0], rx_s};
      tick_q <= hit_c;
    end
  end

  assign bit_tick_c = tick_q;
  assign bit_val_c  = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_tick_c = hit_c;
  assign bit_val_c  = rx_s;
`endif

  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= shreg_nxt;
      par_acc <= par_nxt;
      perr_q  <= perr_nxt;
      ferr_q  <= ferr_nxt;
      armed   <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    par_nxt   = par_acc;
    perr_nxt  = perr_q;
    ferr_nxt  = ferr_q;
    armed_nxt = armed;
    load_c    = 1'b0;

    if (state != S_IDLE) begin
      cnt_nxt = hit_c ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (rx_s) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt = S_START;
          armed_nxt = 1'b0;
          par_nxt   = 1'b0;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (bit_tick_c) begin
          if (bit_val_c) begin
            state_nxt = S_IDLE;
            armed_nxt = 1'b1;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bit_tick_c) begin
          shreg_nxt = {bit_val_c, shreg[DATA_WIDTH-1:1]};
          par_nxt   = par_acc ^ bit_val_c;
          if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            idx_nxt   = '0;
            state_nxt = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_tick_c) begin
          perr_nxt  = par_acc ^ bit_val_c ^ ODD;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick_c) begin
          if (!bit_val_c) ferr_nxt = 1'b1;
          // Leave mid-stop so an immediately following start edge is caught
          if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
            state_nxt = S_IDLE;
            armed_nxt = bit_val_c;
            load_c    = 1'b1;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output word register with valid/ready hold and overrun tracking
  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      if (load_c) begin
        data_out    <= shreg;
        parity_err  <= perr_nxt;
        frame_err   <= ferr_nxt;
        overrun_err <= data_valid & ~data_ready;
        data_valid  <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (8 data bits, 16x oversample, even parity, 1 stop).
// Words are predicted from the transmitted frame and compared at each acceptance.
module tb_uart_rx_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned OS    = 16;
  localparam int unsigned NBITS = 1 + DW + 1 + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned LAT = 1;
  localparam logic [7:0] GLITCH_WORD = 8'hFF;
`else
  localparam int unsigned LAT = 0;
  localparam logic [7:0] GLITCH_WORD = 8'hFD;
`endif

  logic          rx_clk = 1'b0;
  logic          rx_reset;
  logic          rx;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          data_valid, parity_err, frame_err, overrun_err, busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       oe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_cycles = 0;
  logic busy_seen = 1'b0;
  int   vc0;

  always #5 rx_clk = ~rx_clk;

  uart_rx_param #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS),
    .PARITY_MODE(1),
    .STOP_BITS  (1)
  ) dut (
    .rx_clk     (rx_clk),
    .rx_reset   (rx_reset),
    .rx         (rx),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rx_clk);
    #2;
  endtask

  // Reference: a word's parity error is the even-parity check over what arrives
  task automatic expect_word(input logic [7:0] d, input logic parbit, input logic stopv,
                             input logic ovr);
    exp_t e;
    e.d  = d;
    e.pe = (^d) ^ parbit;
    e.fe = ~stopv;
    e.oe = ovr;
    exp_q.push_back(e);
  endtask

  // Drives one frame, one bit per OS cycles; optional one-cycle low glitch and early abort
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopv,
                            input int glitch_at, input int abort_at);
    logic [NBITS-1:0] f;
    f = {stopv, (^d) ^ pflip, d, 1'b0};
    for (int k = 0; k < int'(NBITS * OS); k++) begin
      if (k == abort_at) return;
      rx = (k == glitch_at) ? 1'b0 : f[k / OS];
      step();
    end
  endtask

  // Acceptance monitor, sampled mid-cycle
  always @(negedge rx_clk) begin
    if (rx_reset) begin
      if (data_valid) valid_cycles++;
      if (busy) busy_seen = 1'b1;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(mon_e.d));
          chk("parity_err", 32'(parity_err), 32'(mon_e.pe));
          chk("frame_err", 32'(frame_err), 32'(mon_e.fe));
          chk("overrun_err", 32'(overrun_err), 32'(mon_e.oe));
        end
      end
    end
  end

  initial begin
    rx_reset   = 1'b0;
    rx         = 1'b1;
    data_ready = 1'b1;
    repeat (3) step();
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun_err", 32'(overrun_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rx_reset = 1'b1;
    repeat (5) step();

    // Clean frame, single-cycle valid pulse
    vc0 = valid_cycles;
    expect_word(8'hA5, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
    repeat (20) step();
    chk("valid_pulse_len", 32'(valid_cycles - vc0), 32'd1);

    // Wrong parity bit
    expect_word(8'hA5, 1'b1, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    repeat (20) step();

    // Low stop bit, then line held low: no new start until it goes high
    expect_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, -1, -1);
    busy_seen = 1'b0;
    repeat (40) step();
    chk("no_start_while_low", 32'(busy_seen), 32'd0);
    rx = 1'b1;
    repeat (20) step();
    chk("pending_after_ferr", 32'(exp_q.size()), 32'd0);

    // False start
    vc0 = valid_cycles;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (10) step();
    chk("false_start_busy_seen", 32'(busy_seen), 32'd1);
    chk("false_start_busy_clear", 32'(busy), 32'd0);
    chk("false_start_no_valid", 32'(valid_cycles - vc0), 32'd0);
    repeat (10) step();

    // Back-to-back with no acceptance: second word overwrites first
    data_ready = 1'b0;
    expect_word(8'hC3, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    send_frame(8'hC3, 1'b0, 1'b1, -1, -1);
    repeat (10) step();
    chk("ovr_data", 32'(data_out), 32'hC3);
    chk("ovr_flag", 32'(overrun_err), 32'd1);
    chk("ovr_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk("ovr_valid_drop", 32'(data_valid), 32'd0);
    repeat (5) step();

    // Same, but the first word is accepted on the second load cycle
    expect_word(8'h3C, 1'b0, 1'b1, 1'b0);
    expect_word(8'hC3, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    fork
      send_frame(8'hC3, 1'b0, 1'b1, -1, -1);
      begin
        repeat ((NBITS - 1) * OS + OS / 2 + 2 + LAT) step();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
      end
    join
    repeat (5) step();
    chk("accept_load_data", 32'(data_out), 32'hC3);
    chk("accept_load_ovr", 32'(overrun_err), 32'd0);
    chk("accept_load_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    step();
    repeat (10) step();
    chk("pending_after_ovr", 32'(exp_q.size()), 32'd0);

    // One-cycle low glitch at the middle of data bit 1
    expect_word(GLITCH_WORD, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 2 * OS + OS / 2, -1);
    repeat (20) step();

    // Reset during data bit 4 abandons the frame
    send_frame(8'($urandom), 1'b0, 1'b1, -1, 5 * OS + OS / 2);
    rx_reset = 1'b0;
    rx = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    repeat (2) step();
    rx_reset = 1'b1;
    vc0 = valid_cycles;
    repeat (30) step();
    expect_word(8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, -1, -1);
    repeat (20) step();
    chk("midrst_one_valid", 32'(valid_cycles - vc0), 32'd1);

    // Randomized frames with random parity/stop faults and gaps
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      logic       pf;
      logic       sv;
      int         gap;
      d   = 8'($urandom);
      pf  = ($urandom_range(0, 3) == 0);
      sv  = ($urandom_range(0, 4) != 0);
      gap = sv ? int'($urandom_range(0, 6)) : int'($urandom_range(3, 8));
      expect_word(d, (^d) ^ pf, sv, 1'b0);
      send_frame(d, pf, sv, -1, -1);
      rx = 1'b1;
      repeat (gap) step();
    end
    repeat (30) step();
    chk("pending_final", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
